rb_read_addr_seq: RTL and testbench
===================================

# rb_read_addr_seq

Frame-aware read-address sequencer for the row-buffer BRAM bank. It issues column word addresses with a valid/ready handshake and selects the row buffer being read, rotating through `RB_COUNT` buffers. It consumes one row credit per row, where credits come from the row-buffer write side. It sits between the row-buffer write controller and the window/kernel datapath, and replaces the free-running single-row address counter.

## Interface
- `RB_COUNT`, 8: number of row buffers; `rb_sel` rotates 0..RB_COUNT-1.
- `IMAGE_WIDTH`, 256: pixels per row.
- `IMAGE_HEIGHT`, 256: rows per frame.
- `PIXEL_PER_READ`, 1: pixels per BRAM word. `IMAGE_WIDTH` must be divisible by it. `WORDS = IMAGE_WIDTH/PIXEL_PER_READ`.
- `PAD`, 1: border columns per side. Used only with `RBA_BORDER_CLAMP_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame. Accepted only in IDLE.
- `row_wr_done` in 1: one-cycle pulse from the writer meaning one more row is resident.
- `rd_ready` in 1: downstream accepts the current address.
- `read_addr` out `$clog2(WORDS)`: BRAM word address.
- `rb_sel` out `$clog2(RB_COUNT)`: row buffer being read.
- `rd_valid` out 1: `read_addr`/`rb_sel` are valid.
- `line_last` out 1: qualifies the last word of a row (valid with `rd_valid`).
- `frame_last` out 1: qualifies the last word of the frame.
- `busy` out 1: FSM is not IDLE.
- `done` out 1: one-cycle pulse after the frame's last handshake.
- `err_ovf` out 1: sticky; a credit arrived while credits were already at `RB_COUNT`.

## Operation
- States:
  - IDLE: `start` → WAIT_ROW.
  - WAIT_ROW: `credit>0` → READ.
  - READ: emits words. The last-word handshake goes to ROW_END.
  - ROW_END: if `row==IMAGE_HEIGHT-1` → DONE, else → WAIT_ROW.
  - DONE: → IDLE.
- Credit counter, width `$clog2(RB_COUNT+1)`:
  - +1 on `row_wr_done`.
  - −1 on entry to READ.
  - Both in the same cycle: unchanged.
  - Saturates at `RB_COUNT`. Saturation with an increment sets `err_ovf`.
  - Credits persist across frames.
- READ: column counter `col` starts at 0. It advances only on `rd_valid && rd_ready`. With `rd_ready` low, `read_addr`, `rb_sel` and flags hold stable.
- ROW_END: `rb_sel` increments, wrapping `RB_COUNT-1`→0. `row` increments. `col` clears.
- `rb_sel` is 0 at reset. It is not cleared by `start`; rotation continues across frames to stay aligned with the writer.
- `start` outside IDLE is ignored.
- Flags:
  - `line_last` = `rd_valid && col==last column`.
  - `frame_last` = `line_last && row==IMAGE_HEIGHT-1`.
- `err_ovf` clears only on reset.

## Timing
- Reset values: `read_addr`=0, `rb_sel`=0, `rd_valid`=0, `line_last`=0, `frame_last`=0, `busy`=0, `done`=0, `err_ovf`=0. Also credit=0 and state=IDLE.
- All outputs are registered.
- `start` at cycle T → `busy`=1 at T+1.
- WAIT_ROW with `credit>0` sampled at cycle T → `rd_valid`=1 with `read_addr`=0 at T+1.
- Throughput is one address per cycle while `rd_ready`=1.
- Each row boundary costs two idle cycles (ROW_END, then WAIT_ROW) even when credit is available.
- `done` pulses 2 cycles after the final handshake (ROW_END, then DONE). `busy` falls in the same cycle `done` rises.
- Reset assertion mid-frame immediately forces the reset values. The partial frame is abandoned.

## Configuration
- `RBA_BORDER_CLAMP_EN` defined: each row issues `WORDS+2*PAD` handshakes. The address is clamped:
  - 0 for the first `PAD` handshakes;
  - `WORDS-1` for the last `PAD` handshakes;
  - `col-PAD` otherwise.
  - `line_last` marks the final padded handshake.
  - Requires `PAD < WORDS`.
- Not defined: exactly `WORDS` handshakes per row with `read_addr`=`col`. `PAD` is unused.

## Test plan
- Single row, full rate: W=8, H=1, PPR=1. One `row_wr_done`, then `start`, `rd_ready`=1 → `read_addr` 0..7 on consecutive cycles, `line_last` and `frame_last` on addr 7, `done` 2 cycles later, `rb_sel` ends at 1.
- Backpressure: during READ, `rd_ready` toggles 1,0,0,1 → address holds for the two stalled cycles and no address is skipped or duplicated.
- Credit starvation and rotation: RB_COUNT=4, H=6, credits supplied one at a time with long gaps → `rd_valid` stays 0 in WAIT_ROW; `rb_sel` goes 0,1,2,3,0,1 per row.
- Overflow: RB_COUNT=4, five `row_wr_done` pulses while IDLE → credit stays 4 and `err_ovf`=1 persists through a subsequent frame.
- Reset mid-frame: drop `rst` during READ at col 3 → all outputs zero asynchronously; after release, `start` runs a fresh frame from `read_addr`=0.
- `RBA_BORDER_CLAMP_EN`, W=8, PAD=1 → row sequence 0,0,1,2,3,4,5,6,7,7 with `line_last` on the 10th handshake.

Source files
------------

// File: rtl/rb_read_addr_seq_if.sv
// Read-address bus between rb_read_addr_seq (master) and the window/kernel
// datapath (slave). The master drives the address, row-buffer select and
// qualifying flags; the slave returns rd_ready.
interface rb_read_addr_seq_if #(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 3
);
  logic [ADDR_W-1:0] read_addr;
  logic [SEL_W-1:0]  rb_sel;
  logic              rd_valid;
  logic              rd_ready;
  logic              line_last;
  logic              frame_last;

  modport master (
    output read_addr, rb_sel, rd_valid, line_last, frame_last,
    input  rd_ready
  );

  modport slave (
    input  read_addr, rb_sel, rd_valid, line_last, frame_last,
    output rd_ready
  );
endinterface

// File: rtl/rb_read_addr_seq.sv
// Frame-aware read-address sequencer for the row-buffer BRAM bank.
// Issues column word addresses with valid/ready, rotates the row-buffer
// select through RB_COUNT buffers and consumes one writer credit per row.
// Optional feature macro: RBA_BORDER_CLAMP_EN adds PAD clamped border
// handshakes on each side of every row.
module rb_read_addr_seq #(
  parameter int RB_COUNT       = 8,
  parameter int IMAGE_WIDTH    = 256,
  parameter int IMAGE_HEIGHT   = 256,
  parameter int PIXEL_PER_READ = 1,
  parameter int PAD            = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_row_wr_done,
  output logic o_busy,
  output logic o_done,
  output logic o_err_ovf,
  rb_read_addr_seq_if.master rd
);

  localparam int WORDS = IMAGE_WIDTH / PIXEL_PER_READ;
`ifdef RBA_BORDER_CLAMP_EN
  localparam int CLAMP_EN = 1;
`else
  localparam int CLAMP_EN = 0;
`endif
  // Handshakes per row (padded when border clamping is enabled)
  localparam int NHS = WORDS + 2 * PAD * CLAMP_EN;
  localparam int AW  = (WORDS > 1)        ? $clog2(WORDS)        : 1;
  localparam int SW  = (RB_COUNT > 1)     ? $clog2(RB_COUNT)     : 1;
  localparam int CW  = (NHS > 1)          ? $clog2(NHS)          : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int KW  = $clog2(RB_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_READ,
    S_ROW_END,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_addr;
  logic            r_valid;
  logic            r_line_last;
  logic            r_frame_last;
  logic            r_busy;
  logic            r_done;
  logic [KW-1:0]   r_credit;
  logic            r_err_ovf;

  logic [CW-1:0]   w_col_nxt;
  logic            w_last_row;
  logic            w_take;
  logic            w_col_nxt_last;

  // Map a handshake index within the row to a BRAM word address
  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] c);
`ifdef RBA_BORDER_CLAMP_EN
    if (int'(c) < PAD)
      return '0;
    else if (int'(c) >= WORDS + PAD)
      return AW'(WORDS - 1);
    else
      return AW'(int'(c) - PAD);
`else
    return AW'(c);
`endif
  endfunction

  assign w_col_nxt      = r_col + CW'(1);
  assign w_col_nxt_last = (w_col_nxt == CW'(NHS - 1));
  assign w_last_row     = (r_row == RW'(IMAGE_HEIGHT - 1));
  assign w_take         = (r_state == S_WAIT_ROW) && (r_credit != '0);

  // Frame/row sequencing FSM with registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_sel        <= '0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_line_last  <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_WAIT_ROW;
            r_busy  <= 1'b1;
            r_row   <= '0;
          end
        end
        S_WAIT_ROW: begin
          if (w_take) begin
            r_state      <= S_READ;
            r_col        <= '0;
            r_valid      <= 1'b1;
            r_addr       <= addr_of('0);
            r_line_last  <= (NHS == 1);
            r_frame_last <= (NHS == 1) && w_last_row;
          end
        end
        S_READ: begin
          if (r_valid && rd.rd_ready) begin
            if (r_col == CW'(NHS - 1)) begin
              r_state      <= S_ROW_END;
              r_valid      <= 1'b0;
              r_line_last  <= 1'b0;
              r_frame_last <= 1'b0;
            end else begin
              r_col        <= w_col_nxt;
              r_addr       <= addr_of(w_col_nxt);
              r_line_last  <= w_col_nxt_last;
              r_frame_last <= w_col_nxt_last && w_last_row;
            end
          end
        end
        S_ROW_END: begin
          r_sel <= (r_sel == SW'(RB_COUNT - 1)) ? '0 : r_sel + SW'(1);
          r_col <= '0;
          if (w_last_row) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_row   <= r_row + RW'(1);
            r_state <= S_WAIT_ROW;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Row credit counter; saturates at RB_COUNT, sticky overflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit  <= '0;
      r_err_ovf <= 1'b0;
    end else if (i_row_wr_done && !w_take) begin
      if (r_credit == KW'(RB_COUNT))
        r_err_ovf <= 1'b1;
      else
        r_credit <= r_credit + KW'(1);
    end else if (!i_row_wr_done && w_take) begin
      r_credit <= r_credit - KW'(1);
    end
  end

  assign rd.read_addr  = r_addr;
  assign rd.rb_sel     = r_sel;
  assign rd.rd_valid   = r_valid;
  assign rd.line_last  = r_line_last;
  assign rd.frame_last = r_frame_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_rb_read_addr_seq.sv
// Self-checking bench for rb_read_addr_seq: scoreboard of expected
// handshakes, stall stability, credit starvation/overflow, rotation,
// done timing and mid-frame reset. Honors RBA_BORDER_CLAMP_EN.
module tb_rb_read_addr_seq;
  localparam int RBC   = 4;
  localparam int W     = 8;
  localparam int H     = 2;
  localparam int PPR   = 1;
  localparam int PADC  = 1;
  localparam int WORDS = W / PPR;
`ifdef RBA_BORDER_CLAMP_EN
  localparam int NHS = WORDS + 2 * PADC;
`else
  localparam int NHS = WORDS;
`endif
  localparam int AW = $clog2(WORDS);
  localparam int SW = $clog2(RBC);
  localparam int FULL_CYC = 1 + H * NHS + (H - 1) * 2;

  logic clk;
  logic rst_n;
  logic start;
  logic row_wr_done;
  logic busy;
  logic done;
  logic err_ovf;

  rb_read_addr_seq_if #(.ADDR_W(AW), .SEL_W(SW)) bus ();

  rb_read_addr_seq #(
    .RB_COUNT      (RBC),
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .PIXEL_PER_READ(PPR),
    .PAD           (PADC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_row_wr_done(row_wr_done),
    .o_busy       (busy),
    .o_done       (done),
    .o_err_ovf    (err_ovf),
    .rd           (bus.master)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic          ll;
    logic          fl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_sel = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int addr_of(input int c);
`ifdef RBA_BORDER_CLAMP_EN
    if (c < PADC) return 0;
    if (c >= WORDS + PADC) return WORDS - 1;
    return c - PADC;
`else
    return c;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < NHS; c++) begin
        e.addr = AW'(addr_of(c));
        e.sel  = SW'(exp_sel);
        e.ll   = (c == NHS - 1);
        e.fl   = (c == NHS - 1) && (r == H - 1);
        q.push_back(e);
      end
      exp_sel = (exp_sel + 1) % RBC;
    end
  endtask

  // Pops the scoreboard on each handshake and checks stall stability
  task automatic monitor();
    logic          stall;
    logic [AW-1:0] pa;
    logic [SW-1:0] ps;
    logic          pl;
    logic          pf;
    exp_t          e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", bus.rd_valid, 1);
          chk("stall_addr", bus.read_addr, pa);
          chk("stall_sel", bus.rb_sel, ps);
          chk("stall_ll", bus.line_last, pl);
          chk("stall_fl", bus.frame_last, pf);
        end
        if (bus.rd_valid && bus.rd_ready) begin
          chk("hs_expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("hs_addr", bus.read_addr, e.addr);
            chk("hs_sel", bus.rb_sel, e.sel);
            chk("hs_line_last", bus.line_last, e.ll);
            chk("hs_frame_last", bus.frame_last, e.fl);
          end
        end
        stall = bus.rd_valid && !bus.rd_ready;
        pa = bus.read_addr;
        ps = bus.rb_sel;
        pl = bus.line_last;
        pf = bus.frame_last;
      end
    end
  endtask

  task automatic pulse_credit();
    row_wr_done = 1'b1;
    step();
    row_wr_done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", bus.rd_valid, 0);
  endtask

  // mode 0: rd_ready=1; mode 1: rd_ready pattern 1,0,0,1
  task automatic run_frame(input int mode, input int npulse, input int gap, input int exp_cycles);
    int n;
    int p;
    n = 0;
    p = 0;
    while (q.size() != 0 && n < 3000) begin
      bus.rd_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      if (gap > 0 && p < npulse && (n % gap) == gap - 1) begin
        row_wr_done = 1'b1;
        p++;
      end else begin
        row_wr_done = 1'b0;
      end
      step();
      n++;
    end
    row_wr_done = 1'b0;
    bus.rd_ready = 1'b1;
    chk("frame_drained", q.size(), 0);
    if (exp_cycles > 0) chk("frame_cycles", n, exp_cycles);
    chk("rowend_done", done, 0);
    chk("rowend_busy", busy, 1);
    step();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    step();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("end_sel", bus.rb_sel, exp_sel);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, bus.read_addr, 0);
    chk({tag, "_sel"}, bus.rb_sel, 0);
    chk({tag, "_valid"}, bus.rd_valid, 0);
    chk({tag, "_ll"}, bus.line_last, 0);
    chk({tag, "_fl"}, bus.frame_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_ovf, 0);
  endtask

  initial begin
    logic any_valid;
    int   n;
    rst_n        = 1'b0;
    start        = 1'b0;
    row_wr_done  = 1'b0;
    bus.rd_ready = 1'b1;
    fork
      monitor();
    join_none
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Full-rate frame with credits already resident
    pulse_credit();
    pulse_credit();
    push_frame();
    do_start();
    run_frame(0, 0, 0, FULL_CYC);

    // Backpressure 1,0,0,1
    pulse_credit();
    pulse_credit();
    push_frame();
    do_start();
    run_frame(1, 0, 0, 0);

    // Credit starvation, then credits trickle in with long gaps
    push_frame();
    do_start();
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_valid = any_valid | bus.rd_valid;
    end
    chk("starve_valid", any_valid, 0);
    chk("starve_busy", busy, 1);
    run_frame(0, 2, 15, 0);

    // Overflow: five credits while IDLE, saturation at RB_COUNT
    for (int i = 0; i < 4; i++) pulse_credit();
    chk("ovf_not_yet", err_ovf, 0);
    pulse_credit();
    chk("ovf_set", err_ovf, 1);
    push_frame();
    do_start();
    run_frame(0, 0, 0, FULL_CYC);
    push_frame();
    do_start();
    run_frame(0, 0, 0, FULL_CYC);
    chk("ovf_sticky1", err_ovf, 1);
    push_frame();
    do_start();
    any_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_valid = any_valid | bus.rd_valid;
    end
    chk("sat_no_extra_credit", any_valid, 0);
    run_frame(0, 2, 3, 0);
    chk("ovf_sticky2", err_ovf, 1);

    // Mid-frame reset
    pulse_credit();
    pulse_credit();
    push_frame();
    do_start();
    n = 0;
    while (!(bus.rd_valid && bus.read_addr == AW'(3)) && n < 100) begin
      step();
      n++;
    end
    chk("rst_reach_addr3", bus.read_addr, 3);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    q.delete();
    exp_sel = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    pulse_credit();
    pulse_credit();
    push_frame();
    do_start();
    run_frame(0, 0, 0, FULL_CYC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
